// File: rtl/h2f_lw_mailbox_if.sv
// Avalon-MM slave bus bundle for the h2f_lw_mailbox CSR window.
//
// Strobe semantics: there is no waitrequest, so an access is accepted in
// every cycle its strobe (avs_read or avs_write) is high at the rising clock
// edge. A read returns avs_readdata exactly one cycle later. If both strobes
// are high together, the write is performed and the read returns 0.
interface h2f_lw_mailbox_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );
endinterface

// File: rtl/h2f_lw_mailbox.sv
// HPS lightweight-bridge mailbox: a circular FIFO that software pushes and
// pops through a 4-word CSR window (DATA, STATUS, THRESH, CONTROL), with
// sticky overflow/underflow flags.
//
// Build option: define MAILBOX_IRQ_EN to implement THRESH, CONTROL.irq_en
// and the registered level-threshold interrupt. Without it, irq is tied low
// and THRESH / CONTROL[1] read as 0 and ignore writes.
module h2f_lw_mailbox #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic            clk,
  input  logic            reset,
  h2f_lw_mailbox_if.slave avs,
  output logic            irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_THRESH  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic                  ovf_sticky;
  logic                  unf_sticky;
  logic [DEPTH_LOG2:0]   thresh;
  logic                  irq_en;

  logic wr_acc, rd_acc;
  logic push, pop_req, push_ok, pop_ok;
  logic ovf_set, unf_set, ovf_clr, unf_clr;
  logic flush, empty, full;
  logic [31:0] head_word;
  logic [31:0] status_word;
  logic [31:0] rd_mux;

  // Upper write-data bits have no meaning in some registers; fold them here.
  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata;

  // Access decode: a write always wins over a simultaneous read.
  always_comb begin
    wr_acc  = avs.avs_write;
    rd_acc  = avs.avs_read & ~avs.avs_write;
    empty   = (level == '0);
    full    = (level == FULL_LEVEL);
    push    = wr_acc & (avs.avs_address == ADDR_DATA);
    pop_req = rd_acc & (avs.avs_address == ADDR_DATA);
    push_ok = push & ~full;
    pop_ok  = pop_req & ~empty;
    ovf_set = push & full;
    unf_set = pop_req & empty;
    ovf_clr = wr_acc & (avs.avs_address == ADDR_STATUS) & avs.avs_writedata[18];
    unf_clr = wr_acc & (avs.avs_address == ADDR_STATUS) & avs.avs_writedata[19];
    flush   = wr_acc & (avs.avs_address == ADDR_CONTROL) & avs.avs_writedata[0];
  end

  // Read-side word formatting: zero-extended head, status and config words.
  always_comb begin
    head_word = '0;
    head_word[DATA_WIDTH-1:0] = mem[rd_ptr];
    status_word = '0;
    status_word[DEPTH_LOG2:0] = level;
    status_word[16] = empty;
    status_word[17] = full;
    status_word[18] = ovf_sticky;
    status_word[19] = unf_sticky;
    rd_mux = '0;
    case (avs.avs_address)
      ADDR_DATA:    rd_mux = pop_ok ? head_word : 32'h0;
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_THRESH:  rd_mux[DEPTH_LOG2:0] = thresh;
      ADDR_CONTROL: rd_mux[1] = irq_en;
      default:      rd_mux = '0;
    endcase
  end

  // FIFO storage: written on an accepted, non-overflowing push; no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= avs.avs_writedata[DATA_WIDTH-1:0];
    end
  end

  // Pointer and level bookkeeping; flush rewinds everything to empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (push_ok) begin
      wr_ptr <= wr_ptr + 1'b1;
      level  <= level + 1'b1;
    end else if (pop_ok) begin
      rd_ptr <= rd_ptr + 1'b1;
      level  <= level - 1'b1;
    end
  end

  // Sticky error flags: a new error in the same cycle beats a W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= ovf_set | (ovf_sticky & ~ovf_clr);
      unf_sticky <= unf_set | (unf_sticky & ~unf_clr);
    end
  end

  // Registered read data, one cycle after the read strobe; 0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs.avs_readdata <= '0;
    end else if (rd_acc) begin
      avs.avs_readdata <= rd_mux;
    end else begin
      avs.avs_readdata <= '0;
    end
  end

`ifdef MAILBOX_IRQ_EN
  // Threshold and interrupt-enable configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thresh <= '0;
      irq_en <= 1'b0;
    end else if (wr_acc) begin
      if (avs.avs_address == ADDR_THRESH) begin
        thresh <= avs.avs_writedata[DEPTH_LOG2:0];
      end
      if (avs.avs_address == ADDR_CONTROL) begin
        irq_en <= avs.avs_writedata[1];
      end
    end
  end

  // Level interrupt, registered from the already-updated level register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & (thresh != '0) & (level >= thresh);
    end
  end
`else
  assign thresh = '0;
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_h2f_lw_mailbox.sv
// Testbench for h2f_lw_mailbox: directed scenarios followed by random CSR
// traffic, all checked against a queue-based model of the mailbox.
module tb_h2f_lw_mailbox;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH_LOG2 = 6;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef MAILBOX_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic irq;
  always #5 clk = ~clk;

  h2f_lw_mailbox_if bus ();

  h2f_lw_mailbox #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .avs  (bus),
    .irq  (irq)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl_q[$];
  bit          mdl_ovf;
  bit          mdl_unf;
  logic [6:0]  mdl_thresh;
  bit          mdl_irq_en;

  task automatic mdl_reset();
    mdl_q.delete();
    mdl_ovf = 0;
    mdl_unf = 0;
    mdl_thresh = '0;
    mdl_irq_en = 0;
  endtask

  task automatic mdl_write(input logic [1:0] addr, input logic [31:0] data);
    case (addr)
      2'd0: if (mdl_q.size() == DEPTH) mdl_ovf = 1; else mdl_q.push_back(data);
      2'd1: begin
        if (data[18]) mdl_ovf = 0;
        if (data[19]) mdl_unf = 0;
      end
      2'd2: if (IRQ_ON) mdl_thresh = data[6:0];
      default: begin
        if (data[0]) mdl_q.delete();
        if (IRQ_ON) mdl_irq_en = data[1];
      end
    endcase
  endtask

  task automatic mdl_read(input logic [1:0] addr, output logic [31:0] exp);
    exp = '0;
    case (addr)
      2'd0: if (mdl_q.size() == 0) mdl_unf = 1; else exp = mdl_q.pop_front();
      2'd1: begin
        exp = 32'(mdl_q.size());
        exp[16] = (mdl_q.size() == 0);
        exp[17] = (mdl_q.size() == DEPTH);
        exp[18] = mdl_ovf;
        exp[19] = mdl_unf;
      end
      2'd2: exp = 32'(mdl_thresh);
      default: exp = {30'd0, mdl_irq_en, 1'b0};
    endcase
  endtask

  function automatic bit mdl_irq();
    return IRQ_ON && mdl_irq_en && (mdl_thresh != 0) && (mdl_q.size() >= int'(mdl_thresh));
  endfunction

  // ---------------- driver tasks (entered and left at a falling edge) ----------------
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.avs_address = addr;
    bus.avs_writedata = data;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] got);
    bus.avs_address = addr;
    bus.avs_read = 1'b1;
    @(negedge clk);
    got = bus.avs_readdata;
    bus.avs_read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
    mdl_write(addr, data);
    bus_write(addr, data);
  endtask

  task automatic rd_check(input string tag, input logic [1:0] addr);
    logic [31:0] e, g;
    mdl_read(addr, e);
    exp_q.push_back(e);
    bus_read(addr, g);
    check(tag, g, exp_q.pop_front());
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic irq_check(input string tag);
    check(tag, {31'd0, irq}, {31'd0, mdl_irq()});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] g;
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    mdl_reset();

    // reset state
    #1 reset = 1'b1;
    #1;
    check("rst_readdata", bus.avs_readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle();
    rd_check("rst_status", 2'd1);
    rd_check("rst_thresh", 2'd2);
    rd_check("rst_control", 2'd3);

    // basic push/pop ordering
    do_write(2'd0, 32'h11);
    do_write(2'd0, 32'h22);
    do_write(2'd0, 32'h33);
    rd_check("status_lvl3", 2'd1);
    rd_check("pop_11", 2'd0);
    rd_check("pop_22", 2'd0);
    rd_check("pop_33", 2'd0);
    rd_check("status_empty", 2'd1);

    // simultaneous read and write: write is performed, read returns 0
    mdl_write(2'd0, 32'h77);
    bus.avs_address = 2'd0;
    bus.avs_writedata = 32'h77;
    bus.avs_read = 1'b1;
    bus.avs_write = 1'b1;
    @(negedge clk);
    g = bus.avs_readdata;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    check("rdwr_readdata", g, 32'h0);
    rd_check("rdwr_pop", 2'd0);

    // fill to full, overflow, drain
    for (int i = 0; i < DEPTH; i++) do_write(2'd0, 32'(i));
    do_write(2'd0, 32'hDEAD);
    rd_check("status_full_ovf", 2'd1);
    for (int i = 0; i < DEPTH; i++) rd_check("drain", 2'd0);
    rd_check("status_drained", 2'd1);

    // underflow and sticky clear
    rd_check("underflow_data", 2'd0);
    rd_check("status_unf", 2'd1);
    do_write(2'd1, 32'h000C_0000);
    rd_check("status_w1c", 2'd1);

    // threshold interrupt
    do_write(2'd2, 32'd4);
    do_write(2'd3, 32'h2);
    rd_check("thresh_rd", 2'd2);
    rd_check("control_rd", 2'd3);
    for (int i = 0; i < 4; i++) begin
      do_write(2'd0, 32'h40 + 32'(i));
      check("irq_low_push", {31'd0, irq}, 32'h0);
    end
    idle();
    check("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});
    rd_check("irq_pop", 2'd0);
    check("irq_hold", {31'd0, irq}, {31'd0, IRQ_ON});
    idle();
    check("irq_fall", {31'd0, irq}, 32'h0);
    do_write(2'd3, 32'h0);

    // flush and first-word fall-through round trip
    for (int i = 0; i < 10; i++) do_write(2'd0, 32'h100 + 32'(i));
    do_write(2'd3, 32'h1);
    rd_check("status_flushed", 2'd1);
    do_write(2'd0, 32'hA5A5A5A5);
    rd_check("fwft_a5", 2'd0);

    // asynchronous reset mid-traffic
    rd_check("pre_rst_unf", 2'd0);
    for (int i = 0; i < 5; i++) do_write(2'd0, 32'h200 + 32'(i));
    do_write(2'd2, 32'd4);
    do_write(2'd3, 32'h2);
    idle();
    idle();
    irq_check("pre_rst_irq");
    rd_check("pre_rst_data", 2'd0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_readdata", bus.avs_readdata, 32'h0);
    check("async_rst_irq", {31'd0, irq}, 32'h0);
    mdl_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd_check("post_rst_status", 2'd1);
    rd_check("post_rst_control", 2'd3);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40)      do_write(2'd0, $urandom);
      else if (r < 70) rd_check("rnd_data", 2'd0);
      else if (r < 78) rd_check("rnd_status", 2'd1);
      else if (r < 83) do_write(2'd1, {12'd0, 2'($urandom_range(0, 3)), 18'd0});
      else if (r < 88) do_write(2'd2, 32'($urandom_range(0, 8)));
      else if (r < 92) do_write(2'd3, {30'd0, 1'($urandom_range(0, 1)),
                                       1'($urandom_range(0, 9) == 0)});
      else if (r < 96) rd_check("rnd_thresh", 2'd2);
      else             rd_check("rnd_control", 2'd3);
      idle();
      irq_check("rnd_irq");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
